// File: rtl/dsp_simd_mult_rr_arbiter.sv
// dsp_simd_mult_rr_arbiter
// Round-robin front end that shares one 10x9 DSP multiplier lane between N_REQ
// requesters. Operands are issued at most once per cycle, each issue is tagged
// with its requester id, and the id follows the product through the DSP latency.
// Optional issue counter on busy_cnt_o is built only when DSP_ARB_PERF_EN is defined.
module dsp_simd_mult_rr_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DSP_LATENCY = 1,
    parameter int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [N_REQ-1:0]      req_valid_i,
    output logic [N_REQ-1:0]      req_ready_o,
    input  logic [N_REQ*10-1:0]   req_a_i,
    input  logic [N_REQ*9-1:0]    req_b_i,
    input  logic [N_REQ-1:0]      req_unsigned_a_i,
    input  logic [N_REQ-1:0]      req_unsigned_b_i,
    output logic [9:0]            dsp_a_o,
    output logic [8:0]            dsp_b_o,
    output logic                  dsp_unsigned_a_o,
    output logic                  dsp_unsigned_b_o,
    input  logic [18:0]           dsp_z_i,
    output logic                  res_valid_o,
    output logic [ID_W-1:0]       res_id_o,
    output logic [18:0]           res_z_o,
    output logic [15:0]           busy_cnt_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] grantId;
    logic            grantFound;
    logic            transfer;

    logic [9:0]      selA;
    logic [8:0]      selB;
    logic            selUa, selUb;

    logic [9:0]      dspA_q, dspA_d;
    logic [8:0]      dspB_q, dspB_d;
    logic            dspUa_q, dspUa_d;
    logic            dspUb_q, dspUb_d;

    logic [DSP_LATENCY:0] tagValid_q;
    logic [ID_W-1:0]      tagId_q [DSP_LATENCY+1];

    // Pick the first valid requester at or after the pointer, wrapping to the lowest valid one
    always_comb begin
        logic            anyHi;
        logic [ID_W-1:0] hiId;
        logic [ID_W-1:0] loId;
        anyHi      = 1'b0;
        hiId       = '0;
        loId       = '0;
        grantFound = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                grantFound = 1'b1;
                loId       = ID_W'(i);
                if (i >= int'(ptr_q)) begin
                    anyHi = 1'b1;
                    hiId  = ID_W'(i);
                end
            end
        end
        grantId  = anyHi ? hiId : loId;
        transfer = grantFound && !reset_i;
    end

    // One-hot ready toward the granted requester; a lone requester is always ready out of reset
    always_comb begin
        req_ready_o = '0;
        if (N_REQ == 1) begin
            req_ready_o[0] = !reset_i;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (transfer && (grantId == ID_W'(i))) begin
                    req_ready_o[i] = 1'b1;
                end
            end
        end
    end

    // Steer the granted requester's operands and signedness flags toward the DSP
    always_comb begin
        selA  = '0;
        selB  = '0;
        selUa = 1'b0;
        selUb = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grantId == ID_W'(i)) begin
                selA  = req_a_i[i*10 +: 10];
                selB  = req_b_i[i*9 +: 9];
                selUa = req_unsigned_a_i[i];
                selUb = req_unsigned_b_i[i];
            end
        end
    end

    // Next pointer and DSP input values; everything holds when nothing is transferred
    always_comb begin
        ptr_d   = ptr_q;
        dspA_d  = dspA_q;
        dspB_d  = dspB_q;
        dspUa_d = dspUa_q;
        dspUb_d = dspUb_q;
        if (transfer) begin
            ptr_d   = (grantId == ID_W'(N_REQ - 1)) ? '0 : grantId + ID_W'(1);
            dspA_d  = selA;
            dspB_d  = selB;
            dspUa_d = selUa;
            dspUb_d = selUb;
        end
    end

    // Pointer, DSP input registers and the {valid,id} tag shift register tracking the DSP latency
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ptr_q      <= '0;
            dspA_q     <= '0;
            dspB_q     <= '0;
            dspUa_q    <= 1'b0;
            dspUb_q    <= 1'b0;
            tagValid_q <= '0;
            for (int s = 0; s <= DSP_LATENCY; s++) begin
                tagId_q[s] <= '0;
            end
        end else begin
            ptr_q         <= ptr_d;
            dspA_q        <= dspA_d;
            dspB_q        <= dspB_d;
            dspUa_q       <= dspUa_d;
            dspUb_q       <= dspUb_d;
            tagValid_q[0] <= transfer;
            tagId_q[0]    <= grantId;
            for (int s = 1; s <= DSP_LATENCY; s++) begin
                tagValid_q[s] <= tagValid_q[s-1];
                tagId_q[s]    <= tagId_q[s-1];
            end
        end
    end

    assign dsp_a_o          = dspA_q;
    assign dsp_b_o          = dspB_q;
    assign dsp_unsigned_a_o = dspUa_q;
    assign dsp_unsigned_b_o = dspUb_q;
    assign res_valid_o      = tagValid_q[DSP_LATENCY];
    assign res_id_o         = tagId_q[DSP_LATENCY];
    assign res_z_o          = dsp_z_i;

`ifdef DSP_ARB_PERF_EN
    logic [15:0] busyCnt_q, busyCnt_d;

    // Saturating count of issued operand pairs
    always_comb begin
        busyCnt_d = busyCnt_q;
        if (transfer && (busyCnt_q != 16'hFFFF)) begin
            busyCnt_d = busyCnt_q + 16'd1;
        end
    end

    // Issue counter register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            busyCnt_q <= '0;
        end else begin
            busyCnt_q <= busyCnt_d;
        end
    end

    assign busy_cnt_o = busyCnt_q;
`else
    assign busy_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_dsp_simd_mult_rr_arbiter.sv
// tb_dsp_simd_mult_rr_arbiter
// Directed bench for the round-robin DSP lane arbiter. A small behavioural
// 10x9 multiplier with registered inputs stands in for the DSP lane.
module tb_dsp_simd_mult_rr_arbiter;

    localparam int N = 4;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b1;
    logic [N-1:0]  req_valid_i = '0;
    logic [N-1:0]  req_ready_o;
    logic [N*10-1:0] req_a_i = '0;
    logic [N*9-1:0]  req_b_i = '0;
    logic [N-1:0]  req_unsigned_a_i = '0;
    logic [N-1:0]  req_unsigned_b_i = '0;
    logic [9:0]    dsp_a_o;
    logic [8:0]    dsp_b_o;
    logic          dsp_unsigned_a_o;
    logic          dsp_unsigned_b_o;
    logic [18:0]   dsp_z_i;
    logic          res_valid_o;
    logic [1:0]    res_id_o;
    logic [18:0]   res_z_o;
    logic [15:0]   busy_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    logic [9:0] dspAq = '0;
    logic [8:0] dspBq = '0;
    logic       dspUaq = 1'b0;
    logic       dspUbq = 1'b0;

    dsp_simd_mult_rr_arbiter #(
        .N_REQ(N),
        .DSP_LATENCY(1),
        .ID_W(2)
    ) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_a_i(req_a_i),
        .req_b_i(req_b_i),
        .req_unsigned_a_i(req_unsigned_a_i),
        .req_unsigned_b_i(req_unsigned_b_i),
        .dsp_a_o(dsp_a_o),
        .dsp_b_o(dsp_b_o),
        .dsp_unsigned_a_o(dsp_unsigned_a_o),
        .dsp_unsigned_b_o(dsp_unsigned_b_o),
        .dsp_z_i(dsp_z_i),
        .res_valid_o(res_valid_o),
        .res_id_o(res_id_o),
        .res_z_o(res_z_o),
        .busy_cnt_o(busy_cnt_o)
    );

    // Free-running clock
    always #5 clock_i = ~clock_i;

    // DSP lane stand-in: input registers
    always @(posedge clock_i) begin
        dspAq  <= dsp_a_o;
        dspBq  <= dsp_b_o;
        dspUaq <= dsp_unsigned_a_o;
        dspUbq <= dsp_unsigned_b_o;
    end

    // DSP lane stand-in: product of the registered operands, low 19 bits
    always_comb begin
        logic [19:0] aExt;
        logic [19:0] bExt;
        logic [19:0] prod;
        aExt    = dspUaq ? {10'b0, dspAq} : {{10{dspAq[9]}}, dspAq};
        bExt    = dspUbq ? {11'b0, dspBq} : {{11{dspBq[8]}}, dspBq};
        prod    = aExt * bExt;
        dsp_z_i = prod[18:0];
    end

    task automatic setReq(input int idx, input logic [9:0] a, input logic [8:0] b,
                          input logic ua, input logic ub);
        req_valid_i[idx]         = 1'b1;
        req_a_i[idx*10 +: 10]    = a;
        req_b_i[idx*9 +: 9]      = b;
        req_unsigned_a_i[idx]    = ua;
        req_unsigned_b_i[idx]    = ub;
    endtask

    task automatic clearReqs();
        req_valid_i = '0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        for (int i = 0; i < N; i++) setReq(i, 10'(i + 1), 9'd1, 1'b1, 1'b1);
        repeat (2) @(negedge clock_i);
        #1;
        vectors++;
        if (req_ready_o !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b expected %b", req_ready_o, 4'b0000);
        end
        vectors++;
        if ({res_valid_o, res_id_o} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_res: got valid=%b id=%0d expected 0/0", res_valid_o, res_id_o);
        end
        vectors++;
        if ({dsp_a_o, dsp_b_o, dsp_unsigned_a_o, dsp_unsigned_b_o} !== 21'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_dsp: got a=%h b=%h ua=%b ub=%b expected all 0",
                     dsp_a_o, dsp_b_o, dsp_unsigned_a_o, dsp_unsigned_b_o);
        end
        vectors++;
        if (busy_cnt_o !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_busy: got %h expected 0", busy_cnt_o);
        end
        @(negedge clock_i);
        reset_i = 1'b0;
        clearReqs();
    endtask

    task automatic test_single();
        @(negedge clock_i);
        setReq(0, 10'h3FF, 9'h1FF, 1'b1, 1'b1);
        #1;
        vectors++;
        if (req_ready_o !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL single_ready: got %b expected %b", req_ready_o, 4'b0001);
        end
        @(negedge clock_i);
        clearReqs();
        #1;
        vectors++;
        if (res_valid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_early: got valid=%b expected 0", res_valid_o);
        end
        vectors++;
        if ({dsp_a_o, dsp_b_o, dsp_unsigned_a_o, dsp_unsigned_b_o} !== {10'h3FF, 9'h1FF, 2'b11}) begin
            miscompares++;
            $display("[TB] FAIL single_issue: got a=%h b=%h ua=%b ub=%b expected 3ff/1ff/1/1",
                     dsp_a_o, dsp_b_o, dsp_unsigned_a_o, dsp_unsigned_b_o);
        end
        @(negedge clock_i);
        #1;
        // 1023 * 511 = 522753 = 19'h7FA01
        vectors++;
        if ({res_valid_o, res_id_o, res_z_o} !== {1'b1, 2'd0, 19'h7FA01}) begin
            miscompares++;
            $display("[TB] FAIL single_result: got valid=%b id=%0d z=%h expected 1/0/7fa01",
                     res_valid_o, res_id_o, res_z_o);
        end
        @(negedge clock_i);
        #1;
        vectors++;
        if (res_valid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_once: got valid=%b expected 0", res_valid_o);
        end
    endtask

    task automatic test_signed();
        @(negedge clock_i);
        setReq(1, 10'h3FF, 9'h002, 1'b0, 1'b0);
        #1;
        vectors++;
        if (req_ready_o !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL signed_ready: got %b expected %b", req_ready_o, 4'b0010);
        end
        @(negedge clock_i);
        clearReqs();
        #1;
        vectors++;
        if ({dsp_unsigned_a_o, dsp_unsigned_b_o} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL signed_flags: got %b%b expected 00", dsp_unsigned_a_o, dsp_unsigned_b_o);
        end
        @(negedge clock_i);
        #1;
        vectors++;
        if ({res_valid_o, res_id_o, res_z_o} !== {1'b1, 2'd1, 19'h7FFFE}) begin
            miscompares++;
            $display("[TB] FAIL signed_result: got valid=%b id=%0d z=%h expected 1/1/7fffe",
                     res_valid_o, res_id_o, res_z_o);
        end
    endtask

    task automatic test_rr_skip();
        // pointer sits at 2 here
        @(negedge clock_i);
        setReq(1, 10'h200, 9'h0FF, 1'b0, 1'b0);
        setReq(3, 10'd5, 9'd3, 1'b1, 1'b1);
        #1;
        vectors++;
        if (req_ready_o !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL skip_first: got %b expected %b", req_ready_o, 4'b1000);
        end
        @(negedge clock_i);
        req_valid_i[3] = 1'b0;
        #1;
        vectors++;
        if (req_ready_o !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL skip_second: got %b expected %b", req_ready_o, 4'b0010);
        end
        @(negedge clock_i);
        clearReqs();
        #1;
        vectors++;
        if ({res_valid_o, res_id_o, res_z_o} !== {1'b1, 2'd3, 19'd15}) begin
            miscompares++;
            $display("[TB] FAIL skip_res3: got valid=%b id=%0d z=%h expected 1/3/0000f",
                     res_valid_o, res_id_o, res_z_o);
        end
        @(negedge clock_i);
        #1;
        // -512 * 255 = -130560 -> 19'h60200
        vectors++;
        if ({res_valid_o, res_id_o, res_z_o} !== {1'b1, 2'd1, 19'h60200}) begin
            miscompares++;
            $display("[TB] FAIL skip_res1: got valid=%b id=%0d z=%h expected 1/1/60200",
                     res_valid_o, res_id_o, res_z_o);
        end
        @(negedge clock_i);
        #1;
        vectors++;
        if ({res_valid_o, dsp_a_o, dsp_b_o} !== {1'b0, 10'h200, 9'h0FF}) begin
            miscompares++;
            $display("[TB] FAIL skip_hold: got valid=%b a=%h b=%h expected 0/200/0ff",
                     res_valid_o, dsp_a_o, dsp_b_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] expBusy;
        @(negedge clock_i);
        reset_i = 1'b1;
        @(negedge clock_i);
        reset_i = 1'b0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clock_i);
            if (k < 8) begin
                for (int i = 0; i < N; i++) setReq(i, 10'(i + 1), 9'd2, 1'b1, 1'b1);
            end else begin
                clearReqs();
            end
            #1;
            if (k < 8) begin
                vectors++;
                if (req_ready_o !== 4'(1 << (k % 4))) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_ready[%0d]: got %b expected %b", k, req_ready_o, 4'(1 << (k % 4)));
                end
            end
            if (k >= 2 && k < 10) begin
                vectors++;
                if ({res_valid_o, res_id_o, res_z_o} !== {1'b1, 2'((k - 2) % 4), 19'((((k - 2) % 4) + 1) * 2)}) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_result[%0d]: got valid=%b id=%0d z=%h expected 1/%0d/%0d",
                             k, res_valid_o, res_id_o, res_z_o, (k - 2) % 4, (((k - 2) % 4) + 1) * 2);
                end
            end else if (k == 10) begin
                vectors++;
                if (res_valid_o !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_drain: got valid=%b expected 0", res_valid_o);
                end
            end
        end
        expBusy = `ifdef DSP_ARB_PERF_EN 16'd8 `else 16'd0 `endif ;
        vectors++;
        if (busy_cnt_o !== expBusy) begin
            miscompares++;
            $display("[TB] FAIL b2b_busy: got %0d expected %0d", busy_cnt_o, expBusy);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] expBusy;
        // pointer back at 0; three back-to-back transfers from 0,1,2
        @(negedge clock_i);
        for (int i = 0; i < 3; i++) setReq(i, 10'd3, 9'd3, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clock_i);
            #1;
            vectors++;
            if (req_ready_o !== 4'(1 << k)) begin
                miscompares++;
                $display("[TB] FAIL mid_ready[%0d]: got %b expected %b", k, req_ready_o, 4'(1 << k));
            end
        end
        @(negedge clock_i);
        reset_i = 1'b1;
        for (int i = 0; i < N; i++) setReq(i, 10'd7, 9'd9, 1'b1, 1'b1);
        #1;
        vectors++;
        if (req_ready_o !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL mid_ready_in_reset: got %b expected 0000", req_ready_o);
        end
        @(negedge clock_i);
        reset_i = 1'b0;
        clearReqs();
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (res_valid_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL mid_no_result[%0d]: got valid=%b expected 0", k, res_valid_o);
            end
            @(negedge clock_i);
        end
        vectors++;
        if (busy_cnt_o !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL mid_busy_cleared: got %0d expected 0", busy_cnt_o);
        end
        for (int i = 0; i < N; i++) setReq(i, 10'd7, 9'd9, 1'b1, 1'b1);
        #1;
        vectors++;
        if (req_ready_o !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL mid_ptr_zero: got %b expected 0001", req_ready_o);
        end
        @(negedge clock_i);
        clearReqs();
        @(negedge clock_i);
        #1;
        vectors++;
        if ({res_valid_o, res_id_o, res_z_o} !== {1'b1, 2'd0, 19'd63}) begin
            miscompares++;
            $display("[TB] FAIL mid_after: got valid=%b id=%0d z=%h expected 1/0/0003f",
                     res_valid_o, res_id_o, res_z_o);
        end
        expBusy = `ifdef DSP_ARB_PERF_EN 16'd1 `else 16'd0 `endif ;
        vectors++;
        if (busy_cnt_o !== expBusy) begin
            miscompares++;
            $display("[TB] FAIL mid_busy: got %0d expected %0d", busy_cnt_o, expBusy);
        end
    endtask

`ifdef DSP_ARB_PERF_EN
    task automatic test_perf_saturate();
        @(negedge clock_i);
        reset_i = 1'b1;
        @(negedge clock_i);
        reset_i = 1'b0;
        setReq(0, 10'd1, 9'd1, 1'b1, 1'b1);
        repeat (100) @(negedge clock_i);
        #1;
        vectors++;
        if (busy_cnt_o !== 16'd100) begin
            miscompares++;
            $display("[TB] FAIL perf_count: got %0d expected 100", busy_cnt_o);
        end
        repeat (69900) @(negedge clock_i);
        #1;
        vectors++;
        if (busy_cnt_o !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL perf_saturate: got %h expected ffff", busy_cnt_o);
        end
        repeat (5) @(negedge clock_i);
        #1;
        vectors++;
        if (busy_cnt_o !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL perf_hold: got %h expected ffff", busy_cnt_o);
        end
        clearReqs();
    endtask
`endif

    // Scenario sequence and summary
    initial begin
        test_reset();
        test_single();
        test_signed();
        test_rr_skip();
        test_back_to_back();
        test_reset_mid();
`ifdef DSP_ARB_PERF_EN
        test_perf_saturate();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
